// File: rtl/wsf_pkg.sv
// Shared types and constants for the register-window spill/fill sequencer.
// Included by window_spill_fill and its bench.
package wsf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL,
    S_FILL_RD,
    S_FILL_WR,
    S_DONE
  } wsf_state_e;

  localparam int WSF_REG_FIRST  = 16;
  localparam int WSF_NXFER      = 16;
  localparam int WSF_WORD_BYTES = 4;

endpackage

// File: rtl/window_spill_fill.sv
// Moves one register window (r16..r31) between the register file and the stack.
// Optional WSF_MEM_ERR_EN adds mem_err/err to abort a transfer on a bus error.
module window_spill_fill
  import wsf_pkg::*;
#(
  parameter int NWIN  = 4,
  parameter int NXFER = WSF_NXFER
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     spill_req,
  input  logic                     fill_req,
  input  logic [$clog2(NWIN)-1:0]  win_sel,
  input  logic [31:0]              sp_base,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               rf_cwp,
  output logic [4:0]               rf_addr,
  input  logic [31:0]              rf_rdata,
  output logic [31:0]              rf_wdata,
  output logic                     rf_we,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
`ifdef WSF_MEM_ERR_EN
  input  logic                     mem_err,
  output logic                     err,
`endif
  input  logic                     mem_ack
);

  localparam int WW = $clog2(NWIN);
  localparam int IW = $clog2(NXFER);

  wsf_state_e        state_q;
  logic [IW-1:0]     i_q;
  logic [IW-1:0]     i_d;
  logic [WW-1:0]     win_q;
  logic [31:0]       base_q;
  logic [31:0]       data_q;
  logic              last_w;
  logic              xfer_w;
  logic              ack_bad;
  logic              ack_good;
  logic              unused_sp;

  assign unused_sp = ^sp_base[1:0];

  assign i_d    = i_q + IW'(1);
  assign last_w = (i_q == IW'(NXFER - 1));
  assign xfer_w = (state_q == S_SPILL) || (state_q == S_FILL_RD);

`ifdef WSF_MEM_ERR_EN
  assign ack_bad = mem_ack & mem_err;
`else
  assign ack_bad = 1'b0;
`endif
  assign ack_good = mem_ack & ~ack_bad;

  // Sequencer: accept, step the index per acked word, abort on error
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      win_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (spill_req || fill_req) begin
            state_q <= spill_req ? S_SPILL : S_FILL_RD;
            win_q   <= win_sel;
            base_q  <= {sp_base[31:2], 2'b00};
            i_q     <= '0;
          end
        end
        S_SPILL: begin
          if (ack_bad) begin
            state_q <= S_DONE;
          end else if (ack_good) begin
            i_q <= i_d;
            if (last_w) state_q <= S_DONE;
          end
        end
        S_FILL_RD: begin
          if (ack_bad) begin
            state_q <= S_DONE;
          end else if (ack_good) begin
            data_q  <= mem_rdata;
            state_q <= S_FILL_WR;
          end
        end
        S_FILL_WR: begin
          i_q     <= i_d;
          state_q <= last_w ? S_DONE : S_FILL_RD;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WSF_MEM_ERR_EN
  logic err_q;

  // Error flag lives only for the DONE cycle of an aborted transfer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (xfer_w && ack_bad) begin
      err_q <= 1'b1;
    end else begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`endif

  // Port decode from the registered state; idle drives everything to 0
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rf_cwp    = '0;
    rf_addr   = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_SPILL: begin
        busy      = 1'b1;
        rf_cwp    = 5'(win_q);
        rf_addr   = 5'(WSF_REG_FIRST) + 5'(i_q);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q + 32'(i_q) * 32'(WSF_WORD_BYTES);
        mem_wdata = rf_rdata;
      end
      S_FILL_RD: begin
        busy     = 1'b1;
        rf_cwp   = 5'(win_q);
        mem_req  = 1'b1;
        mem_addr = base_q + 32'(i_q) * 32'(WSF_WORD_BYTES);
      end
      S_FILL_WR: begin
        busy     = 1'b1;
        rf_cwp   = 5'(win_q);
        rf_addr  = 5'(WSF_REG_FIRST) + 5'(i_q);
        rf_wdata = data_q;
        rf_we    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
